// File: rtl/ss_adc_conv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ss_adc_conv_ctrl
// Brief    : Single-slope column ADC sequencer: ramp, edge capture, readout.
// Revision : 1.0
// ============================================================================
module ss_adc_conv_ctrl #(
    parameter int NUM_PIXELS    = 5,
    parameter int RAMP_MAX      = 255,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NUM_PIXELS-1:0]   comp_out,
    output logic                    busy,
    output logic                    ramp_en,
    output logic [7:0]              count,
    output logic                    array_reset,
    output logic [NUM_PIXELS-1:0]   cap_enable,
    input  logic [NUM_PIXELS*8-1:0] stored_values,
    output logic [7:0]              rd_data,
    output logic [7:0]              rd_idx,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic                    done
);

    localparam int              SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [7:0]      RAMP_LAST   = 8'(RAMP_MAX);
    localparam logic [7:0]      LAST_IDX    = 8'(NUM_PIXELS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_RAMP    = 3'd3,
        ST_READOUT = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_PIXELS-1:0]   sync1_q, sync1_d;
    logic [NUM_PIXELS-1:0]   sync_q, sync_d;
    logic [NUM_PIXELS-1:0]   prev_q, prev_d;
    logic [NUM_PIXELS-1:0]   fired_q, fired_d;
    logic [SW-1:0]           settle_cnt_q, settle_cnt_d;
    logic [7:0]              count_q, count_d;
    logic                    busy_q, busy_d;
    logic                    ramp_en_q, ramp_en_d;
    logic                    array_reset_q, array_reset_d;
    logic [7:0]              rd_data_q, rd_data_d;
    logic [7:0]              rd_idx_q, rd_idx_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    done_q, done_d;
    logic                    rd_load;
    logic [7:0]              rd_sel;

    always_comb begin
        state_d      = state_q;
        sync1_d      = comp_out;
        sync_d       = sync1_q;
        prev_d       = sync_q;
        settle_cnt_d = settle_cnt_q;
        rd_data_d    = rd_data_q;
        rd_idx_d     = rd_idx_q;
        rd_valid_d   = rd_valid_q;
        rd_load      = 1'b0;
        rd_sel       = rd_idx_q;

        // First rising edge per pixel, plus forced capture of unfired pixels at full scale.
        cap_enable = '0;
        if (state_q == ST_RAMP) begin
            cap_enable = sync_q & ~prev_q & ~fired_q;
            if (count_q == RAMP_LAST) begin
                cap_enable = cap_enable | ~fired_q;
            end
        end
        fired_d = fired_q | cap_enable;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                fired_d      = '0;
                settle_cnt_d = '0;
                rd_idx_d     = '0;
                rd_data_d    = '0;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_RAMP;
                    prev_d  = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            ST_RAMP: begin
                if (count_q == RAMP_LAST) begin
                    state_d = ST_READOUT;
                end
            end
            ST_READOUT: begin
                if (!rd_valid_q) begin
                    rd_valid_d = 1'b1;
                    rd_load    = 1'b1;
                end else if (rd_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_valid_d = 1'b0;
                        state_d    = ST_DONE;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                        rd_sel   = rd_idx_q + 1'b1;
                        rd_load  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rd_load) begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
                if (rd_sel == 8'(i)) begin
                    rd_data_d = stored_values[i*8 +: 8];
                end
            end
        end

        if (abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            fired_d      = '0;
            settle_cnt_d = '0;
            rd_valid_d   = 1'b0;
            rd_idx_d     = '0;
            rd_data_d    = '0;
        end

        // Outputs are registered from the next state so they align with the state they describe.
        busy_d        = (state_d != ST_IDLE);
        ramp_en_d     = (state_d == ST_RAMP);
        array_reset_d = (state_d == ST_CLEAR);
        done_d        = (state_d == ST_DONE);
        if ((state_q == ST_RAMP) && (state_d == ST_RAMP)) begin
            count_d = count_q + 1'b1;
        end else if ((state_d == ST_READOUT) || (state_d == ST_DONE)) begin
            count_d = count_q;
        end else begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            sync1_q       <= '0;
            sync_q        <= '0;
            prev_q        <= '0;
            fired_q       <= '0;
            settle_cnt_q  <= '0;
            count_q       <= '0;
            busy_q        <= 1'b0;
            ramp_en_q     <= 1'b0;
            array_reset_q <= 1'b0;
            rd_data_q     <= '0;
            rd_idx_q      <= '0;
            rd_valid_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            fired_q       <= fired_d;
            settle_cnt_q  <= settle_cnt_d;
            count_q       <= count_d;
            busy_q        <= busy_d;
            ramp_en_q     <= ramp_en_d;
            array_reset_q <= array_reset_d;
            rd_data_q     <= rd_data_d;
            rd_idx_q      <= rd_idx_d;
            rd_valid_q    <= rd_valid_d;
            done_q        <= done_d;
        end
    end

    assign busy        = busy_q;
    assign ramp_en     = ramp_en_q;
    assign count       = count_q;
    assign array_reset = array_reset_q;
    assign rd_data     = rd_data_q;
    assign rd_idx      = rd_idx_q;
    assign rd_valid    = rd_valid_q;
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ss_adc_conv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ss_adc_conv_ctrl
// Brief    : Scoreboard bench for ss_adc_conv_ctrl with a pixel array model.
// Revision : 1.0
// ============================================================================
module tb_ss_adc_conv_ctrl;

    localparam int NP = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            rd_ready = 1'b1;
    logic [NP-1:0]   comp_out = '0;
    logic            busy, ramp_en, array_reset, rd_valid, done;
    logic [7:0]      count, rd_data, rd_idx;
    logic [NP-1:0]   cap_enable;
    logic [NP*8-1:0] stored_values;
    logic [7:0]      mem [NP];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int cap_cnt [NP] = '{default: 0};
    logic [15:0] exp_q [$];
    logic        prev_stall = 1'b0;
    logic [7:0]  p_idx = '0;
    logic [7:0]  p_data = '0;

    localparam logic [39:0] DEF_CODES  = {8'd5, 8'd202, 8'd52, 8'd52, 8'd12};
    localparam logic [39:0] SAT_CODES  = {8'd0, 8'd202, 8'd255, 8'd52, 8'd12};
    localparam logic [39:0] TOG_CODES  = {8'd5, 8'd202, 8'd52, 8'd22, 8'd12};

    ss_adc_conv_ctrl #(.NUM_PIXELS(NP), .RAMP_MAX(255), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .comp_out(comp_out),
        .busy(busy), .ramp_en(ramp_en), .count(count), .array_reset(array_reset),
        .cap_enable(cap_enable), .stored_values(stored_values), .rd_data(rd_data),
        .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_ready(rd_ready), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel register array: cleared by array_reset, stores count on each strobe.
    always @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (reset || array_reset) mem[i] <= '0;
            else if (cap_enable[i]) mem[i] <= count;
        end
    end
    always_comb begin
        stored_values = '0;
        for (int i = 0; i < NP; i++) stored_values[i*8 +: 8] = mem[i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted transfer, checks stall stability.
    always begin
        @(negedge clk);
        #1;
        if (!reset) begin
            for (int i = 0; i < NP; i++) cap_cnt[i] += int'(cap_enable[i]);
            if (done) done_cnt++;
        end
        if (prev_stall) begin
            chk("stall_valid", 32'(rd_valid), 1);
            chk("stall_idx", 32'(rd_idx), 32'(p_idx));
            chk("stall_data", 32'(rd_data), 32'(p_data));
        end
        if (rd_valid && rd_ready && !reset && !abort) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected idx=%0d data=%0d with empty queue", rd_idx, rd_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("rd_word", {16'd0, rd_idx, rd_data}, {16'd0, e});
            end
        end
        prev_stall = rd_valid && !rd_ready && !reset && !abort;
        p_idx  = rd_idx;
        p_data = rd_data;
    end

    function automatic logic [NP-1:0] levels(input int test, input int c);
        int rise [NP] = '{10, 50, 50, 200, 3};
        logic [NP-1:0] l;
        for (int i = 0; i < NP; i++) l[i] = (c >= rise[i]);
        if (test == 1) begin
            l[2] = 1'b0;
            l[4] = 1'b1;
        end
        if (test == 2) l[1] = ((c >= 20) && (c < 30)) || (c >= 40);
        return l;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ramp_en"}, 32'(ramp_en), 0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_array_reset"}, 32'(array_reset), 0);
        chk({tag, "_cap_enable"}, 32'(cap_enable), 0);
        chk({tag, "_rd_data"}, 32'(rd_data), 0);
        chk({tag, "_rd_idx"}, 32'(rd_idx), 0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // mode 0: ready high, 1: stall 3 cycles at idx 2, 2: reset at idx 2
    task automatic run_conv(input int test, input int mode, input bit pulse_start, input logic [39:0] codes);
        int t0, n, done0, n_exp;
        int cap0 [NP];
        bit stalled;
        stalled  = 1'b0;
        comp_out = (test == 1) ? 5'b10000 : 5'b00000;
        rd_ready = 1'b1;
        n_exp = (mode == 2) ? 2 : NP;
        for (int i = 0; i < n_exp; i++) exp_q.push_back({8'(i), codes[i*8 +: 8]});
        done0 = done_cnt;
        for (int i = 0; i < NP; i++) cap0[i] = cap_cnt[i];

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_on_start", 32'(busy), 1);
        chk("array_reset_clear", 32'(array_reset), 1);
        t0 = cyc;

        n = 0;
        while (!ramp_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ramp_reached", 32'(ramp_en), 1);
        chk("ramp_count0", 32'(count), 0);
        n = 0;
        while (ramp_en && n < 300) begin
            comp_out = levels(test, int'(count));
            start = pulse_start && (count == 8'd60);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("ramp_len", 32'(n), 256);

        n = 0;
        while (!done && n < 100) begin
            if (mode == 1 && !stalled && rd_valid && rd_idx == 8'd2) begin
                rd_ready = 1'b0;
                repeat (3) @(negedge clk);
                rd_ready = 1'b1;
                stalled = 1'b1;
            end else if (mode == 2 && rd_valid && rd_idx == 8'd2) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk_idle("rst_readout");
                chk("rst_queue", 32'(exp_q.size()), 0);
                return;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        chk("done_seen", 32'(done), 1);
        chk("latency", 32'(cyc - t0), (mode == 1) ? 270 : 267);
        @(negedge clk);
        chk("done_pulse_len", 32'(done), 0);
        chk("idle_after_done", 32'(busy), 0);
        chk("count_idle", 32'(count), 0);
        chk("queue_drained", 32'(exp_q.size()), 0);
        chk("done_once", 32'(done_cnt - done0), 1);
        for (int i = 0; i < NP; i++) chk("cap_once", 32'(cap_cnt[i] - cap0[i]), 1);
    endtask

    task automatic abort_test();
        int n, done0, capsum0, capsum1;
        comp_out = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!ramp_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (ramp_en && count != 8'd100 && n < 300) begin
            comp_out = levels(0, int'(count));
            @(negedge clk);
            n++;
        end
        chk("abort_at_100", 32'(count), 100);
        done0 = done_cnt;
        capsum0 = 0;
        for (int i = 0; i < NP; i++) capsum0 += cap_cnt[i];
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort");
        repeat (10) @(negedge clk);
        capsum1 = 0;
        for (int i = 0; i < NP; i++) capsum1 += cap_cnt[i];
        chk("abort_no_cap", 32'(capsum1 - capsum0), 0);
        chk("abort_no_done", 32'(done_cnt - done0), 0);
        chk("abort_stays_idle", 32'(busy), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        run_conv(0, 1, 1'b0, DEF_CODES);
        run_conv(1, 0, 1'b0, SAT_CODES);
        run_conv(2, 0, 1'b1, TOG_CODES);
        abort_test();
        run_conv(0, 0, 1'b0, DEF_CODES);
        run_conv(0, 2, 1'b0, DEF_CODES);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ss_adc_conv_ctrl.md
Name: ss_adc_conv_ctrl

Overview:
Conversion sequencer for the single-slope pixel ADC column.
- Drives the shared 8-bit ramp counter and the ramp-enable line.
- Turns each pixel comparator's first rising edge into a one-cycle capture strobe for the pixel register array (enable/count/stored_values interface).
- After the ramp, streams the stored codes out one pixel at a time over a valid/ready handshake, then signals done.

Parameters:
NUM_PIXELS, 5, number of pixel comparators / register-array entries
RAMP_MAX, 255, final ramp count (≤255); also the saturation code for unfired pixels
SETTLE_CYCLES, 4, ramp-off idle cycles between array clear and ramp start (≥1)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  begin conversion; sampled only in IDLE
abort  in  1  cancel conversion; return to IDLE, no done
comp_out  in  NUM_PIXELS  asynchronous comparator outputs
busy  out  1  high in every state except IDLE
ramp_en  out  1  ramp DAC enable; high only in RAMP
count  out  8  counter value to register array
array_reset  out  1  register-array clear; high only in CLEAR
cap_enable  out  NUM_PIXELS  per-pixel capture strobes to register array
stored_values  in  NUM_PIXELS×8  register-array contents
rd_data  out  8  pixel code being read out
rd_idx  out  8  pixel index of rd_data
rd_valid  out  1  rd_data/rd_idx valid
rd_ready  in  1  downstream accepts
done  out  1  one-cycle pulse, conversion and readout complete

Behaviour:
- Reset values:
  - state=IDLE.
  - busy, ramp_en, array_reset, rd_valid, done = 0.
  - count=0, cap_enable=0, rd_data=0, rd_idx=0.
  - Sync flops, prev and fired vectors = 0.
- comp_out passes through a 2-flop synchronizer per bit giving sync[i]. prev[i] is sync[i] delayed one cycle.
- States:
  - IDLE: start=1 -> CLEAR.
  - CLEAR: one cycle. array_reset=1, fired cleared, count=0. Then -> SETTLE.
  - SETTLE: SETTLE_CYCLES cycles, ramp_en=0. Then -> RAMP with count=0 and prev forced to 0.
  - RAMP: ramp_en=1. count increments by 1 each cycle from 0. In the cycle count==RAMP_MAX -> READOUT. count holds RAMP_MAX through READOUT and is cleared in IDLE.
  - READOUT: rd_idx walks 0..NUM_PIXELS-1. rd_data=stored_values[rd_idx], rd_valid=1. Advance on rd_valid&rd_ready. Transfer of the last index -> DONE.
  - DONE: one cycle, done=1. Then -> IDLE.
- Capture rule in RAMP:
  - cap_enable[i] = sync[i] & ~prev[i] & ~fired[i], combinational from flops. The array stores the count value present in that same cycle.
  - fired[i] sets on the strobe. Later edges of that pixel are ignored.
  - A comparator already high at ramp entry strobes in the first RAMP cycle and stores 0.
- Saturation: in the RAMP cycle with count==RAMP_MAX, cap_enable[i]=1 for every pixel with fired[i]=0. That pixel stores RAMP_MAX. A real edge in that same cycle also yields RAMP_MAX, so the result is identical.
- Simultaneous edges: any number of pixels may strobe in one cycle. No arbitration is needed.
- cap_enable is 0 outside RAMP.
- Readout ordering: rd_valid goes high the cycle after entering READOUT. rd_data/rd_idx are stable while rd_valid & ~rd_ready. There is no combinational path from rd_ready to rd_valid.
- Back-to-back conversions: start ignored while busy. start held high in IDLE after DONE begins a new conversion immediately.
- abort has priority over all transitions in any non-IDLE state.
  - Next cycle: IDLE, all outputs at reset values, done not pulsed.
  - Captured array contents are left unchanged.
- Reset mid-operation: same as abort, and also clears the synchronizer flops.
- Total cycles, start accepted to done, with rd_ready tied high: 1 + SETTLE_CYCLES + (RAMP_MAX+1) + 1 + NUM_PIXELS + 1.

Test Plan:
- Defaults: comp_out rises for pixels 0..4 at ramp cycles 10,50,50,200,3. Strobes occur when the synchronizer delay lets count read 12,52,52,202,5. Readout gives idx0..4 = 12,52,52,202,5, then done pulses once.
- Pixel 2 never fires and pixel 4 is high before start: pixel 2 strobes at count=255 and reads 255; pixel 4 reads 0.
- Pixel 1 toggles (rise, fall, rise at cycles 20, 30, 40): only one cap_enable[1] pulse occurs, and the code reflects the cycle-20 edge.
- rd_ready low 3 cycles during idx 2: rd_valid stays 1 with rd_data/rd_idx stable. Transfer completes on the first ready cycle, and there are no duplicate or skipped indices.
- abort at count=100: next cycle state is IDLE with busy=0, ramp_en=0, no done, and no further cap_enable. Then start runs a full conversion with correct codes.
- start pulsed during RAMP is ignored. reset asserted in READOUT puts all outputs at reset values the next cycle.
